// File: rtl/cache_control_if.sv
// CPU, physical-memory and array-control signals of the L1 cache controller.
// The slave modport belongs to the controller and the master modport belongs to its environment.
interface cache_control_if #(
    parameter int cnt_width = 32
);
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_resp;
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_resp;
    logic [1:0]           hit;
    logic [1:0]           valid;
    logic [1:0]           dirty;
    logic                 lru;
    logic [1:0]           load_tag;
    logic [1:0]           load_valid;
    logic [1:0]           load_dirty;
    logic                 dirty_in;
    logic                 load_lru;
    logic                 lru_in;
    logic [1:0]           load_data;
    logic                 data_src;
    logic                 pmem_addr_sel;
    logic                 way_sel;
    logic [cnt_width-1:0] miss_count;

    modport slave (
        input  mem_read, mem_write, pmem_resp, hit, valid, dirty, lru,
        output mem_resp, pmem_read, pmem_write, load_tag, load_valid, load_dirty,
               dirty_in, load_lru, lru_in, load_data, data_src, pmem_addr_sel,
               way_sel, miss_count
    );

    modport master (
        output mem_read, mem_write, pmem_resp, hit, valid, dirty, lru,
        input  mem_resp, pmem_read, pmem_write, load_tag, load_valid, load_dirty,
               dirty_in, load_lru, lru_in, load_data, data_src, pmem_addr_sel,
               way_sel, miss_count
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for a 2-way set-associative L1 cache: handles hits, dirty-victim writeback,
// line fill, and a saturating miss counter.
module cache_control #(
    parameter int cnt_width = 32
) (
    input  logic            clk,
    input  logic            rst,
    cache_control_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [cnt_width-1:0] miss_count_q, miss_count_d;

    logic       req_s;
    logic       hw_s;
    logic       mem_resp_s, pmem_read_s, pmem_write_s;
    logic [1:0] load_tag_s, load_valid_s, load_dirty_s, load_data_s;
    logic       dirty_in_s, load_lru_s, lru_in_s, data_src_s, pmem_addr_sel_s, way_sel_s;

    assign req_s = bus.mem_read | bus.mem_write;
    assign hw_s  = bus.hit[0] ? 1'b0 : 1'b1;

    // State and miss-counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            miss_count_q <= {cnt_width{1'b0}};
        end else begin
            state_q      <= state_d;
            miss_count_q <= miss_count_d;
        end
    end

    // Next-state and array/memory control decode
    always_comb begin
        state_d         = state_q;
        miss_count_d    = miss_count_q;
        mem_resp_s      = 1'b0;
        pmem_read_s     = 1'b0;
        pmem_write_s    = 1'b0;
        load_tag_s      = 2'b00;
        load_valid_s    = 2'b00;
        load_dirty_s    = 2'b00;
        load_data_s     = 2'b00;
        dirty_in_s      = 1'b0;
        load_lru_s      = 1'b0;
        lru_in_s        = 1'b0;
        data_src_s      = 1'b0;
        pmem_addr_sel_s = 1'b0;
        way_sel_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s && (|bus.hit)) begin
                    mem_resp_s = 1'b1;
                    way_sel_s  = hw_s;
                    load_lru_s = 1'b1;
                    lru_in_s   = ~hw_s;
                    if (bus.mem_write) begin
                        load_data_s[hw_s]  = 1'b1;
                        load_dirty_s[hw_s] = 1'b1;
                        dirty_in_s         = 1'b1;
                    end else begin
                        dirty_in_s = 1'b0;
                    end
                end else if (req_s) begin
                    if (miss_count_q != {cnt_width{1'b1}}) begin
                        miss_count_d = miss_count_q + {{(cnt_width-1){1'b0}}, 1'b1};
                    end else begin
                        miss_count_d = miss_count_q;
                    end
                    // Only a valid and dirty victim needs to be written back before the fill
                    if (bus.valid[bus.lru] && bus.dirty[bus.lru]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                pmem_write_s    = 1'b1;
                pmem_addr_sel_s = 1'b1;
                way_sel_s       = bus.lru;
                if (bus.pmem_resp) begin
                    state_d = ALLOCATE;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            ALLOCATE: begin
                pmem_read_s = 1'b1;
                way_sel_s   = bus.lru;
                if (bus.pmem_resp) begin
                    load_data_s[bus.lru]  = 1'b1;
                    data_src_s            = 1'b1;
                    load_tag_s[bus.lru]   = 1'b1;
                    load_valid_s[bus.lru] = 1'b1;
                    load_dirty_s[bus.lru] = 1'b1;
                    dirty_in_s            = 1'b0;
                    state_d               = IDLE;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset must silence the Mealy outputs combinationally, not only at the next edge
    assign bus.mem_resp      = mem_resp_s & ~rst;
    assign bus.pmem_read     = pmem_read_s & ~rst;
    assign bus.pmem_write    = pmem_write_s & ~rst;
    assign bus.load_tag      = load_tag_s & {2{~rst}};
    assign bus.load_valid    = load_valid_s & {2{~rst}};
    assign bus.load_dirty    = load_dirty_s & {2{~rst}};
    assign bus.load_data     = load_data_s & {2{~rst}};
    assign bus.dirty_in      = dirty_in_s & ~rst;
    assign bus.load_lru      = load_lru_s & ~rst;
    assign bus.lru_in        = lru_in_s & ~rst;
    assign bus.data_src      = data_src_s & ~rst;
    assign bus.pmem_addr_sel = pmem_addr_sel_s & ~rst;
    assign bus.way_sel       = way_sel_s & ~rst;
    assign bus.miss_count    = miss_count_q;
endmodule

// File: tb/tb_cache_control.sv
// Randomised scoreboard bench for cache_control: the bench owns a behavioural model of the
// tag/valid/dirty/LRU arrays and predicts every response, writeback and fill it should see.
module tb_cache_control;
    localparam int CW = 2;

    logic clk;
    logic rst;
    cache_control_if #(.cnt_width(CW)) bus ();

    cache_control #(.cnt_width(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic          way;
        logic          ld_lru;
        logic          lru_in;
        logic [1:0]    ld_data;
        logic [1:0]    ld_dirty;
        logic          dirty_in;
        logic          data_src;
        logic [1:0]    pmem;
        logic [CW-1:0] cnt;
    } resp_t;

    resp_t exp_resp_q[$];
    logic  exp_wb_q[$];
    logic  exp_fill_q[$];

    logic [1:0] m_tag [4][2];
    logic [1:0] m_valid [4];
    logic [1:0] m_dirty [4];
    logic       m_lru [4];
    int         m_cnt;

    int n_cmp;
    int n_bad;
    bit mem_hold;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] hitvec(input int s, input logic [1:0] tg);
        logic [1:0] h;
        for (int w = 0; w < 2; w++) h[w] = m_valid[s][w] && (m_tag[s][w] == tg);
        return h;
    endfunction

    task automatic drive_inputs(input int s, input logic [1:0] tg);
        bus.hit   = hitvec(s, tg);
        bus.valid = m_valid[s];
        bus.dirty = m_dirty[s];
        bus.lru   = m_lru[s];
    endtask

    // Expected hit response from the current model state; returns the hit way
    task automatic push_hit(input int s, input logic [1:0] tg, input bit wr, output logic way);
        resp_t r;
        logic [1:0] h;
        h = hitvec(s, tg);
        way = h[0] ? 1'b0 : 1'b1;
        r = '0;
        r.way      = way;
        r.ld_lru   = 1'b1;
        r.lru_in   = ~way;
        r.ld_data  = wr ? (way ? 2'b10 : 2'b01) : 2'b00;
        r.ld_dirty = r.ld_data;
        r.dirty_in = wr;
        r.cnt      = CW'(m_cnt);
        exp_resp_q.push_back(r);
    endtask

    task automatic do_req(input bit wr, input int s, input logic [1:0] tg, input bit drop);
        logic way;
        logic victim;
        bit   done;
        bus.mem_write = wr;
        bus.mem_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_inputs(s, tg);
        if (|hitvec(s, tg)) begin
            push_hit(s, tg, wr, way);
        end else begin
            if (m_cnt < 3) m_cnt++;
            victim = m_lru[s];
            if (m_valid[s][victim] && m_dirty[s][victim]) exp_wb_q.push_back(victim);
            exp_fill_q.push_back(victim);
            @(posedge clk);
            #1;
            if (drop) begin
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                if (bus.pmem_read && bus.pmem_resp) done = 1'b1;
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL fill_timeout: got no fill within 40 cycles, required one");
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
                return;
            end
            @(posedge clk);
            m_tag[s][victim]   = tg;
            m_valid[s][victim] = 1'b1;
            m_dirty[s][victim] = 1'b0;
            #1;
            drive_inputs(s, tg);
            if (drop) return;
            push_hit(s, tg, wr, way);
        end
        @(posedge clk);
        m_lru[s] = ~way;
        if (wr) m_dirty[s][way] = 1'b1;
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        drive_inputs(s, tg);
    endtask

    // Physical memory: answers each pmem request after a random latency
    initial begin
        int lat;
        lat = 0;
        bus.pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
            end else if ((bus.pmem_read || bus.pmem_write) && !mem_hold) begin
                if (lat == 0) begin
                    bus.pmem_resp = 1'b1;
                    lat = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end
        end
    end

    // Response monitor: every mem_resp must match the oldest predicted response
    initial begin
        resp_t act, exp;
        forever begin
            @(negedge clk);
            if (!rst && bus.mem_resp) begin
                act = {bus.way_sel, bus.load_lru, bus.lru_in, bus.load_data, bus.load_dirty,
                       bus.dirty_in, bus.data_src, {bus.pmem_read, bus.pmem_write}, bus.miss_count};
                if (exp_resp_q.size() == 0) begin
                    chk("unexpected_resp", 32'(act), 32'(0));
                end else begin
                    exp = exp_resp_q.pop_front();
                    chk("resp", 32'(act), 32'(exp));
                end
            end
        end
    end

    // Memory-side monitor: writeback and fill completions, and read/write exclusion
    initial begin
        logic v;
        logic [1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("pmem_rw_exclusive", 32'(bus.pmem_read & bus.pmem_write), 32'(0));
                if (bus.pmem_resp && bus.pmem_write) begin
                    v = (exp_wb_q.size() != 0) ? exp_wb_q.pop_front() : ~bus.way_sel;
                    chk("writeback", 32'({bus.pmem_addr_sel, bus.way_sel, bus.pmem_read,
                                          bus.load_data, bus.load_tag}),
                        32'({1'b1, v, 1'b0, 2'b00, 2'b00}));
                end
                if (bus.pmem_resp && bus.pmem_read) begin
                    v  = (exp_fill_q.size() != 0) ? exp_fill_q.pop_front() : ~bus.way_sel;
                    oh = v ? 2'b10 : 2'b01;
                    chk("fill", 32'({bus.load_tag, bus.load_valid, bus.load_dirty, bus.load_data,
                                     bus.data_src, bus.dirty_in, bus.pmem_addr_sel, bus.way_sel,
                                     bus.load_lru, bus.mem_resp}),
                        32'({oh, oh, oh, oh, 1'b1, 1'b0, 1'b0, v, 1'b0, 1'b0}));
                end
            end
        end
    end

    initial begin
        bit found;
        n_cmp = 0;
        n_bad = 0;
        mem_hold = 1'b0;
        m_cnt = 0;
        for (int s = 0; s < 4; s++) begin
            m_valid[s] = 2'b00;
            m_dirty[s] = 2'b00;
            m_lru[s]   = 1'b0;
            for (int w = 0; w < 2; w++) m_tag[s][w] = 2'd0;
        end
        m_valid[0] = 2'b10; m_tag[0][1] = 2'd1;
        m_valid[1] = 2'b01; m_tag[1][0] = 2'd3;

        // Reset with a hitting request present: outputs must stay quiet
        rst = 1'b1;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.hit = 2'b01; bus.valid = 2'b01; bus.dirty = 2'b00; bus.lru = 1'b0;
        #3;
        chk("rst_outputs", 32'({bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_lru,
                                bus.load_data, bus.load_tag, bus.load_valid, bus.load_dirty}), 32'(0));
        chk("rst_miss_count", 32'(bus.miss_count), 32'(0));
        bus.mem_read = 1'b0;
        #14;
        rst = 1'b0;
        drive_inputs(0, 2'd0);

        // Miss that is reset while ALLOCATE waits on memory
        @(posedge clk); #1;
        mem_hold = 1'b1;
        bus.mem_read = 1'b1;
        drive_inputs(0, 2'd2);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.pmem_read) found = 1'b1;
        end
        chk("alloc_reached", 32'(found), 32'(1));
        chk("miss_count_pre_rst", 32'(bus.miss_count), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_alloc", 32'({bus.pmem_read, bus.pmem_write, bus.mem_resp, bus.load_data,
                                  bus.load_tag, bus.load_valid, bus.load_dirty, bus.load_lru}), 32'(0));
        chk("rst_mid_alloc_cnt", 32'(bus.miss_count), 32'(0));
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_hold = 1'b0;
        m_cnt = 0;
        exp_resp_q.delete(); exp_wb_q.delete(); exp_fill_q.delete();
        @(posedge clk); #1;

        // Directed hits: read hit on way 1, write hit on way 0
        do_req(1'b0, 0, 2'd1, 1'b0);
        do_req(1'b1, 1, 2'd3, 1'b0);

        // Random traffic exercising clean/dirty misses, drops and counter saturation
        for (int t = 0; t < 300; t++) begin
            do_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("final_miss_count", 32'(bus.miss_count), 32'(m_cnt));
        chk("resp_queue_drained", 32'(exp_resp_q.size()), 32'(0));
        chk("wb_queue_drained", 32'(exp_wb_q.size()), 32'(0));
        chk("fill_queue_drained", 32'(exp_fill_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
